cpu_fetch_unit: RTL and testbench
=================================

// Module: cpu_fetch_unit
// PURPOSE
//  Instruction-fetch stage of the multi-cycle MIPS core; sits directly upstream of the decode/control unit.
//  Owns the PC and the supervisor bit PC[31], and fetches from instruction memory over a ready handshake.
//  Presents Instruct/PC_high/Interrupt to the control unit and applies its PCSrc to compute the next PC.
//  Also latches and masks the external timer interrupt and vectors interrupts and exceptions.
// PARAMETERS
//  RESET_PC   32'h8000_0000  PC loaded on reset (kernel mode)
//  ILLOP_PC   32'h8000_0004  interrupt vector
//  XADR_PC    32'h8000_0008  exception vector
// PORTS
//  clk         in   1   core clock, all state on rising edge
//  reset       in   1   synchronous, active-low reset (0 = reset)
//  irq_in      in   1   level interrupt request from timer peripheral
//  imem_req    out  1   fetch request, held until imem_ready
//  imem_addr   out  32  fetch address; equals PC while imem_req=1
//  imem_ready  in   1   rdata valid this cycle; completes the request
//  imem_rdata  in   32  fetched word
//  Instruct    out  32  current instruction to control/datapath
//  inst_valid  out  1   execute cycle: the rest of the core commits state only when 1
//  PC          out  32  address of Instruct
//  PC_high     out  1   PC[31]; 1 = kernel mode
//  PC_plus4    out  32  link value for jal/jalr/interrupt/exception
//  Interrupt   out  1   taken interrupt, valid only with inst_valid
//  PCSrc       in   3   from control: 000 seq, 001 branch, 010 j/jal, 011 jr/jalr
//  Exception   in   1   from decode: undefined instruction this execute cycle
//  branch_take in   1   ALUOut[0] of the branch compare
//  jr_target   in   32  register rs value (DatabusA)
// BEHAVIOUR
//  - Reset (reset=0 at a clock edge): state=FETCH, PC=RESET_PC, Instruct=0, inst_valid=0, Interrupt=0, irq_pending=0.
//    imem_req asserts in the first cycle after reset is released.
//  - FSM FETCH: imem_req=1, imem_addr=PC. When imem_ready=1, Instruct<=imem_rdata and state goes to EXEC.
//    Wait states are unbounded; no timeout.
//  - FSM EXEC: lasts exactly 1 cycle with inst_valid=1. PC<=next_pc at the end of the cycle, then state goes to FETCH.
//    Minimum is 2 cycles per instruction.
//  - irq_pending: set on any cycle with irq_in=1; cleared only when an interrupt is taken.
//  - Interrupt = EXEC & irq_pending & ~PC[31] & ~Exception. Interrupts stay masked in kernel mode and remain pending.
//  - next_pc priority:
//    - Exception -> XADR_PC
//    - Interrupt -> ILLOP_PC
//    - PCSrc=001 & branch_take -> ConBA
//    - PCSrc=010 -> JT
//    - PCSrc=011 -> jr_target
//    - else -> PC_plus4
//  - Address arithmetic:
//    - PC_plus4 = {PC[31], PC[30:0]+4}; the low 31 bits wrap and bit31 is never carried into.
//    - ConBA = {PC[31], PC_plus4[30:0] + (sext(Instruct[15:0])<<2)}, wrapping mod 2^31.
//    - JT = {PC[31], PC_plus4[30:28], Instruct[25:0], 2'b00}.
//    - jr: next PC[31] = PC[31] & jr_target[31]. jr may leave kernel mode but never enter it.
//    - Undefined PCSrc codes (1xx) behave as 000.
//  - Simultaneous events:
//    - Exception and irq together: the exception wins and irq stays pending.
//    - irq_in asserted in the same EXEC cycle in which a pending interrupt is taken: pending ends set.
//  - Reset mid-fetch: imem_req drops the next cycle. A coincident imem_ready is ignored.
// CONFIGURATION
//  IRQ_SYNC_EN defined:
//    - irq_in passes through a 2-flop synchronizer (reset to 0) before the pending latch.
//    - Adds 2 cycles of interrupt latency.
//  IRQ_SYNC_EN undefined:
//    - irq_in feeds the pending latch directly; irq_in must be synchronous to clk.
// STRUCTURE
//  Package cpu_defs_pkg holds:
//    - PCSRC_SEQ/BRANCH/JUMP/JR encodings
//    - vector constants RESET_PC/ILLOP_PC/XADR_PC
//    - FSM state encodings FETCH/EXEC
//  One combinational sub-module, cpu_next_pc: PC_plus4, ConBA, JT, the priority mux and the PC[31] rule.
//  The FSM, PC register, Instruct register and irq logic stay in cpu_fetch_unit.
// TESTING
//  1. Reset and sequential fetch.
//     - Stimulus: reset low for 2 cycles, imem_ready with 0 wait states, PCSrc=000.
//     - Required: imem_addr = 80000000, 80000004, 80000008; inst_valid every 2nd cycle.
//  2. Wait states.
//     - Stimulus: imem_ready withheld for 5 cycles.
//     - Required: imem_req and imem_addr hold steady; exactly one inst_valid pulse after ready.
//  3. Branch and jump, with PC=00000010.
//     - Stimulus: beq with imm=FFFF, branch_take=1.
//       Required: next PC=00000010.
//     - Stimulus: PCSrc=010 with Instruct[25:0]=0000040.
//       Required: next PC=00000100.
//  4. jr kernel/user rule.
//     - Stimulus: PC=80000020, jr_target=00400000.
//       Required: next PC=00400000.
//     - Stimulus: PC=00000020, jr_target=80001000.
//       Required: next PC=00001000.
//  5. Interrupt masking and priority.
//     - Stimulus: irq pulse while PC[31]=1.
//       Required: Interrupt=0 until user mode, then one pulse and next PC=80000004.
//     - Stimulus: Exception and irq together.
//       Required: next PC=80000008; irq stays pending.
//  6. Reset mid-fetch.
//     - Stimulus: reset=0 in a wait state while imem_ready=1.
//     - Required: Instruct=0 and PC=80000000 after the edge.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared constants for the fetch stage: PCSrc encodings, PC vectors and FSM state codes.
package cpu_defs_pkg;

   localparam logic [2:0] PCSRC_SEQ    = 3'b000;
   localparam logic [2:0] PCSRC_BRANCH = 3'b001;
   localparam logic [2:0] PCSRC_JUMP   = 3'b010;
   localparam logic [2:0] PCSRC_JR     = 3'b011;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam logic [31:0] ILLOP_PC = 32'h8000_0004;
   localparam logic [31:0] XADR_PC  = 32'h8000_0008;

   localparam logic [0:0] FETCH = 1'b0;
   localparam logic [0:0] EXEC  = 1'b1;

endpackage

// File: rtl/cpu_next_pc.sv
// Next-PC computation: PC+4, branch/jump targets, vector priority and the supervisor-bit rule.
module cpu_next_pc
   import cpu_defs_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [25:0] target_field,
   input  logic [2:0]  pcsrc,
   input  logic        branch_take,
   input  logic [31:0] jr_target,
   input  logic        exception,
   input  logic        interrupt,
   output logic [31:0] pc_plus4,
   output logic [31:0] next_pc
);

   logic [30:0] br_off;
   logic [31:0] conba;
   logic [31:0] jt;
   logic [31:0] jr_pc;

   always_comb begin
      // Bit 31 is the mode bit; address arithmetic wraps within the low 31 bits.
      pc_plus4 = {pc[31], pc[30:0] + 31'd4};
      br_off   = {{13{target_field[15]}}, target_field[15:0], 2'b00};
      conba    = {pc[31], pc_plus4[30:0] + br_off};
      jt       = {pc[31], pc_plus4[30:28], target_field, 2'b00};
      jr_pc    = {pc[31] & jr_target[31], jr_target[30:0]};

      if (exception) begin
         next_pc = XADR_PC;
      end else if (interrupt) begin
         next_pc = ILLOP_PC;
      end else begin
         case (pcsrc)
            PCSRC_SEQ:    next_pc = pc_plus4;
            PCSRC_BRANCH: next_pc = branch_take ? conba : pc_plus4;
            PCSRC_JUMP:   next_pc = jt;
            PCSRC_JR:     next_pc = jr_pc;
            default:      next_pc = pc_plus4;
         endcase
      end
   end

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction-fetch stage: PC/Instruct registers, FETCH/EXEC sequencing and interrupt latch.
// Define IRQ_SYNC_EN to put a 2-flop synchronizer in front of the pending latch.
//
// state | meaning
// FETCH | imem_req high, waiting for imem_ready to capture the instruction
// EXEC  | one cycle, inst_valid high, PC advances at the end of the cycle
module cpu_fetch_unit
   import cpu_defs_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        irq_in,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instruct,
   output logic        inst_valid,
   output logic [31:0] PC,
   output logic        PC_high,
   output logic [31:0] PC_plus4,
   output logic        Interrupt,
   input  logic [2:0]  PCSrc,
   input  logic        Exception,
   input  logic        branch_take,
   input  logic [31:0] jr_target
);

   logic [0:0]  state_q, state_d;
   logic        run_q, run_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        pend_q, pend_d;
   logic        irq_src;
   logic [31:0] next_pc;

`ifdef IRQ_SYNC_EN
   logic [1:0] sync_q, sync_d;
   assign sync_d  = {sync_q[0], irq_in};
   assign irq_src = sync_q[1];
`else
   assign irq_src = irq_in;
`endif

   // run_q keeps imem_req low until the first cycle after reset is released.
   assign imem_req   = run_q & (state_q == FETCH);
   assign imem_addr  = pc_q;
   assign Instruct   = instr_q;
   assign inst_valid = (state_q == EXEC);
   assign PC         = pc_q;
   assign PC_high    = pc_q[31];
   assign Interrupt  = inst_valid & pend_q & ~pc_q[31] & ~Exception;

   cpu_next_pc u_next_pc (
      .pc           (pc_q),
      .target_field (instr_q[25:0]),
      .pcsrc        (PCSrc),
      .branch_take  (branch_take),
      .jr_target    (jr_target),
      .exception    (Exception),
      .interrupt    (Interrupt),
      .pc_plus4     (PC_plus4),
      .next_pc      (next_pc)
   );

   always_comb begin
      run_d   = 1'b1;
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      case (state_q)
         FETCH: begin
            if (imem_req && imem_ready) begin
               instr_d = imem_rdata;
               state_d = EXEC;
            end
         end
         EXEC: begin
            pc_d    = next_pc;
            state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
      // A new request in the taking cycle survives the clear.
      pend_d = (pend_q & ~Interrupt) | irq_src;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= FETCH;
         run_q   <= 1'b0;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0;
         pend_q  <= 1'b0;
`ifdef IRQ_SYNC_EN
         sync_q  <= 2'b00;
`endif
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pend_q  <= pend_d;
`ifdef IRQ_SYNC_EN
         sync_q  <= sync_d;
`endif
      end
   end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Scoreboard bench for cpu_fetch_unit: directed instruction stream with hand-computed PCs.
module tb_cpu_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        irq_in;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] Instruct;
   logic        inst_valid;
   logic [31:0] PC;
   logic        PC_high;
   logic [31:0] PC_plus4;
   logic        Interrupt;
   logic [2:0]  PCSrc;
   logic        Exception;
   logic        branch_take;
   logic [31:0] jr_target;

   cpu_fetch_unit dut (
      .clk(clk), .reset(reset), .irq_in(irq_in),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .Instruct(Instruct), .inst_valid(inst_valid), .PC(PC), .PC_high(PC_high), .PC_plus4(PC_plus4),
      .Interrupt(Interrupt), .PCSrc(PCSrc), .Exception(Exception), .branch_take(branch_take),
      .jr_target(jr_target)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        intr;
      int          gap;
   } exp_t;

   exp_t        exec_q[$];
   logic [31:0] fetch_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          last_valid = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: fetch addresses and executed instructions against the queues.
   always @(negedge clk) begin
      if (imem_req === 1'b1) begin
         if (fetch_q.size() > 0) begin
            cmp("imem_addr", imem_addr, fetch_q[0]);
            if (imem_ready === 1'b1) void'(fetch_q.pop_front());
         end else if (imem_ready === 1'b1) begin
            cmp("unexpected_fetch", 32'd1, 32'd0);
         end
      end
      if (inst_valid === 1'b1) begin
         if (exec_q.size() == 0) begin
            cmp("unexpected_inst_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exec_q.pop_front();
            cmp("PC", PC, e.pc);
            cmp("Instruct", Instruct, e.instr);
            cmp("PC_high", {31'd0, PC_high}, {31'd0, e.pc[31]});
            cmp("PC_plus4", PC_plus4, {e.pc[31], e.pc[30:0] + 31'd4});
            cmp("Interrupt", {31'd0, Interrupt}, {31'd0, e.intr});
            if (e.gap > 0) cmp("valid_gap", cyc - last_valid, e.gap);
         end
         last_valid = cyc;
      end
   end

   // Called at posedge+1 with the DUT in FETCH.
   task automatic do_instr(input logic [31:0] pc, input logic [31:0] word, input int waits,
                           input int gap, input logic [2:0] src, input logic bt,
                           input logic [31:0] jr, input logic exc, input logic intr,
                           input logic irq_f, input logic irq_x);
      exp_t e;
      e.pc = pc; e.instr = word; e.intr = intr; e.gap = gap;
      fetch_q.push_back(pc);
      exec_q.push_back(e);
      cmp("imem_req_fetch", {31'd0, imem_req}, 32'd1);
      irq_in = irq_f;
      for (int i = 0; i < waits; i++) begin
         @(posedge clk); #1;
         irq_in = 1'b0;
         cmp("imem_req_wait", {31'd0, imem_req}, 32'd1);
         cmp("inst_valid_wait", {31'd0, inst_valid}, 32'd0);
      end
      imem_ready = 1'b1;
      imem_rdata = word;
      @(posedge clk); #1;
      imem_ready  = 1'b0;
      imem_rdata  = 32'hxxxx_xxxx;
      irq_in      = irq_x;
      PCSrc       = src;
      branch_take = bt;
      jr_target   = jr;
      Exception   = exc;
      @(posedge clk); #1;
      irq_in      = 1'b0;
      PCSrc       = 3'b000;
      branch_take = 1'b0;
      jr_target   = 32'h0;
      Exception   = 1'b0;
   endtask

   localparam logic [31:0] W_JR  = 32'h0080_0008;
   localparam logic [31:0] W_UND = 32'hFC00_0000;

   initial begin
      reset = 1'b0; irq_in = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
      PCSrc = 3'b000; Exception = 1'b0; branch_take = 1'b0; jr_target = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      cmp("rst_PC", PC, 32'h8000_0000);
      cmp("rst_Instruct", Instruct, 32'h0);
      cmp("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      cmp("rst_Interrupt", {31'd0, Interrupt}, 32'd0);
      cmp("rst_imem_req", {31'd0, imem_req}, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      //        pc            word          w  gap src     bt    jr            exc   int   irqf  irqx
      do_instr(32'h8000_0000, 32'h0000_0000, 0, 0, 3'b000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0);
      do_instr(32'h8000_0004, 32'h2401_0001, 0, 2, 3'b000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0);
      do_instr(32'h8000_0008, 32'h2402_0002, 0, 2, 3'b100, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0);
      do_instr(32'h8000_000C, 32'h1000_0004, 5, 7, 3'b001, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0);
      do_instr(32'h8000_0020, W_JR,          0, 2, 3'b011, 1'b0, 32'h0040_0000, 1'b0, 1'b0, 1'b0, 1'b0);
      do_instr(32'h0040_0000, W_JR,          0, 2, 3'b011, 1'b0, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b0);
      do_instr(32'h0000_0010, 32'h1000_FFFF, 0, 2, 3'b001, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0);
      do_instr(32'h0000_0010, 32'h0800_0040, 0, 2, 3'b010, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0);
      do_instr(32'h0000_0100, W_JR,          0, 2, 3'b011, 1'b0, 32'h8000_1000, 1'b0, 1'b0, 1'b0, 1'b0);
      do_instr(32'h0000_1000, W_UND,         0, 2, 3'b000, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0);
      do_instr(32'h8000_0008, 32'h0000_0000, 0, 2, 3'b000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0);
      do_instr(32'h8000_000C, W_JR,          0, 2, 3'b011, 1'b0, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b0);
      do_instr(32'h0000_0200, 32'h0000_0000, 0, 2, 3'b000, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0);
      do_instr(32'h8000_0004, W_JR,          0, 2, 3'b011, 1'b0, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b0);
      do_instr(32'h0000_0300, W_UND,         0, 2, 3'b000, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0);
      do_instr(32'h8000_0008, W_JR,          0, 2, 3'b011, 1'b0, 32'h0000_0400, 1'b0, 1'b0, 1'b0, 1'b0);
      do_instr(32'h0000_0400, 32'h0000_0000, 0, 2, 3'b000, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1);
      do_instr(32'h8000_0004, W_JR,          0, 2, 3'b011, 1'b0, 32'h0000_0500, 1'b0, 1'b0, 1'b0, 1'b0);
      do_instr(32'h0000_0500, 32'h0000_0000, 0, 2, 3'b000, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0);
      do_instr(32'h8000_0004, 32'h1000_FFFF, 0, 2, 3'b001, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0);

      // Reset lands in a wait state together with imem_ready.
      fetch_q.push_back(32'h8000_0008);
      @(posedge clk); #1;
      cmp("imem_req_prereset", {31'd0, imem_req}, 32'd1);
      reset      = 1'b0;
      imem_ready = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      imem_ready = 1'b0;
      cmp("midrst_Instruct", Instruct, 32'h0);
      cmp("midrst_PC", PC, 32'h8000_0000);
      cmp("midrst_inst_valid", {31'd0, inst_valid}, 32'd0);
      cmp("midrst_imem_req", {31'd0, imem_req}, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      do_instr(32'h8000_0000, 32'h2403_0003, 0, 0, 3'b000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      cmp("exec_q_drained", exec_q.size(), 32'd0);
      cmp("fetch_q_drained", fetch_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
